// File: rtl/encoder8_3_sequential_pkg.sv
// ----------------------------------------------------------------------------
// enc_pkg
// Shared constants, state type and helpers for encoder8_3_sequential and
// its priority-encoder sub-block.
//   REQ_W    : request vector width (only 8 is supported)
//   CODE_W   : output code width, log2(REQ_W)
//   state_t  : IDLE / SERVE
//   is_onehot: true when exactly one bit of the vector is set
// ----------------------------------------------------------------------------
package enc_pkg;

  localparam int REQ_W  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  // Non-zero and clearing the lowest set bit leaves nothing behind.
  function automatic logic is_onehot(input logic [REQ_W-1:0] v);
    return (v != '0) && ((v & (v - REQ_W'(1))) == '0);
  endfunction

endpackage : enc_pkg

// File: rtl/prio_enc8.sv
// ----------------------------------------------------------------------------
// prio_enc8
// Purely combinational 8-to-3 priority encoder; the highest set bit wins.
// Ports:
//   pending [REQ_W-1:0]  in   vector to encode
//   code    [CODE_W-1:0] out  index of the highest set bit (0 when none set)
//   any_set              out  at least one bit of pending is set
// ----------------------------------------------------------------------------
module prio_enc8
  import enc_pkg::*;
(
  input  logic [REQ_W-1:0]  pending,
  output logic [CODE_W-1:0] code,
  output logic              any_set
);

  always_comb begin
    code    = '0;
    any_set = |pending;
    // Ascending scan so the last (highest) hit overrides earlier ones.
    for (int i = 0; i < REQ_W; i++) begin
      if (pending[i]) begin
        code = CODE_W'(i);
      end
    end
  end

endmodule : prio_enc8

// File: rtl/encoder8_3_sequential.sv
// ----------------------------------------------------------------------------
// encoder8_3_sequential
// Latches an 8-bit request vector over a valid/ready handshake and then emits
// the 3-bit index of every set bit, highest index first, one per handshake.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   en          in   enables capture of new requests (drains are unaffected)
//   req[7:0]    in   request vector, bit i requests code i
//   req_valid   in   req is valid this cycle
//   req_ready   out  block can capture req this cycle (IDLE and en)
//   code[2:0]   out  index of the highest pending bit
//   code_valid  out  code is valid (SERVE)
//   code_ready  in   consumer accepts code
//   last        out  current code is the final one of this request
//   busy        out  block is in SERVE
//   zero_err    out  (only with ENC_ZERO_ERR_EN defined) one-cycle pulse
//                    after an all-zero request is accepted
// Build option: define ENC_ZERO_ERR_EN to add the zero_err output.
// ----------------------------------------------------------------------------
module encoder8_3_sequential
  import enc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [REQ_W-1:0]  req,
  input  logic              req_valid,
  output logic              req_ready,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic              last,
`ifdef ENC_ZERO_ERR_EN
  output logic              zero_err,
`endif
  output logic              busy
);

  state_t           state_reg, state_next;
  logic [REQ_W-1:0] pending_reg, pending_next;
  logic             any_set;
  logic             req_fire;
  logic             code_fire;

  // Code comes only from the latched vector, never straight from req.
  prio_enc8 u_prio_enc8 (
    .pending (pending_reg),
    .code    (code),
    .any_set (any_set)
  );

  assign busy       = (state_reg == SERVE);
  assign code_valid = busy;
  assign req_ready  = (state_reg == IDLE) && en;
  assign last       = is_onehot(pending_reg);
  assign req_fire   = req_valid && req_ready;
  assign code_fire  = code_valid && code_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    case (state_reg)
      IDLE: begin
        // An all-zero request is accepted but leaves nothing to serve.
        if (req_fire && (req != '0)) begin
          pending_next = req;
          state_next   = SERVE;
        end
      end
      SERVE: begin
        if (code_fire) begin
          pending_next = pending_reg & ~(REQ_W'(1) << code);
          if (last) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next   = IDLE;
        pending_next = '0;
      end
    endcase
  end

`ifdef ENC_ZERO_ERR_EN
  logic zero_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_err_reg <= 1'b0;
    end else begin
      zero_err_reg <= req_fire && (req == '0);
    end
  end

  assign zero_err = zero_err_reg;
`endif

  // any_set is redundant with busy here; kept on the encoder for reuse.
  logic unused_any_set;
  assign unused_any_set = any_set;

endmodule : encoder8_3_sequential

// File: tb/tb_encoder8_3_sequential.sv
// ----------------------------------------------------------------------------
// tb_encoder8_3_sequential
// Self-checking bench: a queue-based model of the pending codes is compared
// against the DUT every falling edge; directed scenarios pin the model with
// literal code sequences, followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_encoder8_3_sequential;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'h00;
  logic       req_valid = 1'b0;
  logic       code_ready = 1'b0;
  logic       req_ready;
  logic [2:0] code;
  logic       code_valid;
  logic       last;
  logic       busy;
`ifdef ENC_ZERO_ERR_EN
  logic       zero_err;
`endif

  encoder8_3_sequential dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .last       (last),
`ifdef ENC_ZERO_ERR_EN
    .zero_err   (zero_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    fails  = 0;
  string code_log = "";
  string last_log = "";

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got \"%s\" expected \"%s\" (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the queue holds the codes still owed, in emission order.
  int mq[$];
  bit m_zero = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_zero = 1'b0;
    end else begin
      m_zero = 1'b0;
      if (mq.size() != 0) begin
        if (code_ready) void'(mq.pop_front());
      end else if (en && req_valid) begin
        if (req == 8'h00) m_zero = 1'b1;
        else for (int i = 7; i >= 0; i--) if (req[i]) mq.push_back(i);
      end
    end
  end

  // Compare process plus transfer log (inputs only change just after posedge).
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready", int'(req_ready), int'(mq.size() == 0 && en));
      chk("code_valid", int'(code_valid), int'(mq.size() != 0));
      chk("busy", int'(busy), int'(mq.size() != 0));
      chk("last", int'(last), int'(mq.size() == 1));
      if (mq.size() != 0) chk("code", int'(code), mq[0]);
`ifdef ENC_ZERO_ERR_EN
      chk("zero_err", int'(zero_err), int'(m_zero));
`endif
      if (code_valid && code_ready) begin
        code_log = {code_log, $sformatf("%0d", code)};
        last_log = {last_log, $sformatf("%0d", last)};
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    code_log = "";
    last_log = "";
  endtask

  initial begin
    // Reset state while rst_n is held low.
    cyc(2);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_code_valid", int'(code_valid), 0);
    chk("rst_last", int'(last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_code", int'(code), 0);
    rst_n = 1'b1;
    cyc(1);

    // 1: 1010_0100 drains as 7,5,2.
    en = 1'b1; code_ready = 1'b1; clear_log();
    req = 8'hA4; req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
    cyc(5);
    chk_str("t1_codes", code_log, "752");
    chk_str("t1_last", last_log, "001");
    $display("t1 codes=%s last=%s", code_log, last_log);

    // 2: single bit with a 4-cycle stall.
    clear_log(); code_ready = 1'b0;
    req = 8'h01; req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
    cyc(4);
    chk("t2_stall_valid", int'(code_valid), 1);
    code_ready = 1'b1;
    cyc(3);
    chk_str("t2_codes", code_log, "0");
    chk_str("t2_last", last_log, "1");
    $display("t2 codes=%s last=%s", code_log, last_log);

    // 3: en low blocks capture; en low mid-drain does not stop it.
    clear_log(); en = 1'b0;
    req = 8'hFF; req_valid = 1'b1;
    cyc(3);
    chk("t3_blocked_valid", int'(code_valid), 0);
    en = 1'b1;
    cyc(1);
    req_valid = 1'b0;
    cyc(3);
    en = 1'b0;
    cyc(8);
    chk_str("t3_codes", code_log, "76543210");
    $display("t3 codes=%s last=%s", code_log, last_log);
    en = 1'b1;

    // 4: all-zero request is accepted and dropped.
    clear_log();
    req = 8'h00; req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
    chk("t4_busy", int'(busy), 0);
`ifdef ENC_ZERO_ERR_EN
    chk("t4_zero_err_hi", int'(zero_err), 1);
    cyc(1);
    chk("t4_zero_err_lo", int'(zero_err), 0);
`else
    cyc(1);
`endif
    cyc(2);
    chk_str("t4_codes", code_log, "");
    $display("t4 codes=%s", code_log);

    // 5: asynchronous reset after the code-7 transfer.
    clear_log();
    req = 8'hC0; req_valid = 1'b1;
    cyc(1);
    req_valid = 1'b0;
    cyc(1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", int'(code_valid), 0);
    chk("t5_async_busy", int'(busy), 0);
    chk("t5_async_last", int'(last), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(4);
    chk("t5_ready_after", int'(req_ready), 1);
    chk_str("t5_codes", code_log, "7");
    $display("t5 codes=%s", code_log);

    // 6: back-to-back requests with req_valid held.
    clear_log();
    req = 8'h81; req_valid = 1'b1;
    cyc(1);
    req = 8'h02;
    cyc(3);
    req_valid = 1'b0;
    cyc(4);
    chk_str("t6_codes", code_log, "701");
    chk_str("t6_last", last_log, "011");
    $display("t6 codes=%s last=%s", code_log, last_log);

    // Randomized phase, model-checked every cycle.
    for (int n = 0; n < 3000; n++) begin
      en         = ($urandom_range(0, 7) != 0);
      req_valid  = $urandom_range(0, 1);
      req        = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      code_ready = ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    req_valid = 1'b0; code_ready = 1'b1;
    cyc(10);
    chk("final_idle", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_encoder8_3_sequential

// File: doc/encoder8_3_sequential.md
Name: encoder8_3_sequential

Overview:
- Inverse of the team's 3-to-8 decoder.
- Accepts an 8-bit request vector over a valid/ready handshake and latches it.
- Emits the 3-bit binary index of every set bit, one per handshake, highest index first.
- Sits between request-collection logic and any consumer expecting 3-bit select codes, such as the decoder feeding a one-hot select bus.

Parameters:
- REQ_W, 8, request vector width; only 8 is supported.
- CODE_W, 3, output code width; must equal log2(REQ_W).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  enables capture of new requests; does not affect a drain already in progress
- req  input  8  request vector; bit i requests code i
- req_valid  input  1  req is valid this cycle
- req_ready  output  1  block can capture req this cycle
- code  output  3  index of the highest pending bit
- code_valid  output  1  code is valid
- code_ready  input  1  consumer accepts code
- last  output  1  the current code is the final one of this request
- busy  output  1  block is in the SERVE state

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset values:
  - state is IDLE, pending is 0.
  - req_ready, code_valid, last and busy are 0.
  - code is 3'b000.
- States:
  - IDLE: req_ready = en. code_valid = 0.
  - SERVE: code_valid = 1. req_ready = 0.
- Transition out of IDLE when req_valid & req_ready:
  - req != 0: pending <= req and move to SERVE. code_valid rises in the next cycle (1-cycle latency).
  - req == 0: the request is accepted and dropped. State stays IDLE.
- Code generation:
  - code is the index of the highest set bit of pending.
  - It is driven combinationally from the pending register; no path from req to code.
  - last = exactly one bit of pending is set.
- Transfer in SERVE when code_valid & code_ready:
  - Clear pending[code].
  - If last, return to IDLE. req_ready can assert in the following cycle.
  - Otherwise stay in SERVE; the next code is presented in the next cycle (1 code/cycle).
- Stall: code_valid = 1 with code_ready = 0 holds code, last and pending stable indefinitely.
- Throughput: a request with k set bits occupies k SERVE cycles plus at least 1 IDLE cycle. Minimum spacing between accepted requests is k+1 cycles.
- en:
  - en low in IDLE forces req_ready = 0. Requests are not captured.
  - en low in SERVE has no effect; the drain completes.
- Reset asserted mid-drain: immediately clears state and pending. Remaining codes are lost and no partial transfer completes.
- req and req_valid are ignored outside IDLE.
- busy = (state == SERVE).

Optional Feature:
- Macro: ENC_ZERO_ERR_EN.
- Defined:
  - Adds output port zero_err (1 bit, reset 0).
  - zero_err pulses high for exactly one cycle, the cycle after an all-zero req is accepted in IDLE.
  - State still stays IDLE.
- Undefined: the port is absent and all-zero requests are silently dropped.

Decomposition:
- Package enc_pkg holds:
  - REQ_W and CODE_W constants.
  - The state enum typedef (IDLE, SERVE).
  - A function for the one-hot test used by last.
- Sub-module prio_enc8: purely combinational 8-to-3 highest-bit priority encoder.
  - Inputs: pending vector.
  - Outputs: code and any_set.
  - It is reusable elsewhere and is instantiated once here.

Test Plan:
- Reset release; en=1, req=8'b1010_0100 with req_valid for 1 cycle, code_ready=1 held → code_valid on the next cycle with codes 7, 5, 2 on consecutive cycles; last=1 only with code 2; req_ready=1 the cycle after.
- req=8'b0000_0001 with code_ready=0 for 4 cycles then 1 → code=0, last=1, code_valid held for 4 cycles; one transfer, then IDLE.
- en=0 with req_valid=1, req=8'hFF → req_ready stays 0 and code_valid stays 0. Then en=1 → capture, eight codes 7 down to 0; toggle en=0 mid-drain and confirm all eight codes still appear.
- req=8'h00 accepted → state stays IDLE, code_valid=0. With ENC_ZERO_ERR_EN defined, zero_err=1 for exactly one cycle.
- Send 8'b1100_0000; assert rst_n=0 asynchronously after the code-7 transfer → code_valid, busy and last drop without a clock edge. After release, req_ready=1 and no code 6 appears.
- Back-to-back requests 8'h81 then 8'h02 with req_valid held → codes 7, 0, then 1. The second request is accepted only after the IDLE cycle.
